// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: state encoding,
// default terminator word and instruction field positions.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HI,
        LO,
        WRITE,
        CHK,
        DONE
    } state_t;

    localparam logic [15:0] END_WORD_DEF = 16'hFFFF;

    // Instruction word layout: opcode[15:10] | reg[9] | address[8:0]
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 10;
    localparam int unsigned REG_BIT = 9;
    localparam int unsigned ADR_MSB = 8;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input handshake plus instruction-memory write bus.
// master: upstream source / memory side; slave: the loader.
interface instr_loader_if #(
    parameter int ADDR_W = 9
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_loader_pack.sv
// Byte-pair assembler: high byte then low byte into a 16-bit holding
// register. With INSTR_LOADER_CHECKSUM_EN it also keeps a running XOR
// of every accepted byte.
module instr_loader_pack
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        take_hi,
    input  logic        take_lo,
    input  logic [7:0]  byte_in,
`ifdef INSTR_LOADER_CHECKSUM_EN
    output logic [7:0]  chk_sum,
`endif
    output logic [15:0] hold
);

    // Latch each accepted byte into its half of the holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold <= '0;
        end else begin
            if (take_hi) hold[OPC_MSB -: 8]   <= byte_in;
            if (take_lo) hold[ADR_MSB-1 -: 8] <= byte_in;
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Running XOR of accepted word bytes, restarted with each load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_sum <= '0;
        end else if (clr) begin
            chk_sum <= '0;
        end else if (take_hi || take_lo) begin
            chk_sum <= chk_sum ^ byte_in;
        end
    end
`endif

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: takes a program as a byte stream, writes 16-bit
// words to consecutive instruction-memory addresses from 0, and raises
// fin_file when END_WORD has been written (or memory is full).
// Optional: INSTR_LOADER_CHECKSUM_EN adds a trailing checksum byte and chk_err.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int          ADDR_W   = 9,
    parameter int          DEPTH    = 512,
    parameter logic [15:0] END_WORD = END_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bgn,
    instr_loader_if.slave     bus,
    output logic [ADDR_W:0]   word_count,
    output logic              fin_file,
`ifdef INSTR_LOADER_CHECKSUM_EN
    output logic              chk_err,
`endif
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic              in_ready_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       hold;
    logic              xfer;
    logic              clr;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        chk_sum;
`endif

    assign xfer = bus.in_valid && in_ready_q;
    assign clr  = (state == IDLE) && bgn;

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = addr_q;
    assign bus.wr_data  = hold;

    instr_loader_pack u_pack (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .take_hi (xfer && (state == HI)),
        .take_lo (xfer && (state == LO)),
        .byte_in (bus.in_data),
`ifdef INSTR_LOADER_CHECKSUM_EN
        .chk_sum (chk_sum),
`endif
        .hold    (hold)
    );

    // Load sequencer with registered handshake, strobe and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            word_count <= '0;
            fin_file   <= 1'b0;
            overflow   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            chk_err    <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bgn) begin
                        addr_q     <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                        fin_file   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        chk_err    <= 1'b0;
`endif
                        in_ready_q <= 1'b1;
                        state      <= HI;
                    end
                end
                HI: begin
                    if (xfer) state <= LO;
                end
                LO: begin
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        wr_en_q    <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    word_count <= word_count + 1'b1;
                    if (hold == END_WORD) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        in_ready_q <= 1'b1;
                        state      <= CHK;
`else
                        fin_file   <= 1'b1;
                        state      <= DONE;
`endif
                    end else if (addr_q == LAST) begin
                        overflow   <= 1'b1;
                        fin_file   <= 1'b1;
                        state      <= DONE;
                    end else begin
                        addr_q     <= addr_q + 1'b1;
                        in_ready_q <= 1'b1;
                        state      <= HI;
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        chk_err    <= (bus.in_data != chk_sum);
                        in_ready_q <= 1'b0;
                        fin_file   <= 1'b1;
                        state      <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (!bgn) state <= IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: random and directed byte streams
// checked against a word-level reference model. Two instances share the
// stream; the second is built with DEPTH=4 for the overflow case.
module tb_instr_loader;

    localparam int ADDR_W = 9;

    logic clk = 1'b0;
    logic rst;
    logic s_bgn;
    logic sel;
    logic [7:0] s_data;
    logic s_valid;

    always #5 clk = ~clk;

    instr_loader_if #(.ADDR_W(ADDR_W)) bus_a ();
    instr_loader_if #(.ADDR_W(ADDR_W)) bus_b ();

    assign bus_a.in_data  = s_data;
    assign bus_a.in_valid = s_valid;
    assign bus_b.in_data  = s_data;
    assign bus_b.in_valid = s_valid;

    logic [ADDR_W:0] wc_a, wc_b;
    logic fin_a, fin_b, ovf_a, ovf_b;
    logic bgn_a, bgn_b;
    assign bgn_a = s_bgn && !sel;
    assign bgn_b = s_bgn && sel;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic chk_a, chk_b, m_chk;
    assign m_chk = sel ? chk_b : chk_a;
`endif

    instr_loader #(.ADDR_W(ADDR_W), .DEPTH(512), .END_WORD(16'hFFFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .bgn        (bgn_a),
        .bus        (bus_a),
        .word_count (wc_a),
        .fin_file   (fin_a),
`ifdef INSTR_LOADER_CHECKSUM_EN
        .chk_err    (chk_a),
`endif
        .overflow   (ovf_a)
    );

    instr_loader #(.ADDR_W(ADDR_W), .DEPTH(4), .END_WORD(16'hFFFF)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .bgn        (bgn_b),
        .bus        (bus_b),
        .word_count (wc_b),
        .fin_file   (fin_b),
`ifdef INSTR_LOADER_CHECKSUM_EN
        .chk_err    (chk_b),
`endif
        .overflow   (ovf_b)
    );

    logic              m_ready, m_wr_en, m_fin, m_ovf;
    logic [ADDR_W-1:0] m_wr_addr;
    logic [15:0]       m_wr_data;
    logic [ADDR_W:0]   m_wc;
    assign m_ready   = sel ? bus_b.in_ready : bus_a.in_ready;
    assign m_wr_en   = sel ? bus_b.wr_en    : bus_a.wr_en;
    assign m_wr_addr = sel ? bus_b.wr_addr  : bus_a.wr_addr;
    assign m_wr_data = sel ? bus_b.wr_data  : bus_a.wr_data;
    assign m_wc      = sel ? wc_b  : wc_a;
    assign m_fin     = sel ? fin_b : fin_a;
    assign m_ovf     = sel ? ovf_b : ovf_a;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream, model results and driver progress (written only by the driver)
    logic [7:0]  stim[$];
    logic [24:0] exp_w[$];
    int          exp_cons;
    logic        exp_ovf, exp_chk;
    int          idx;
    int          load_base;

    // Monitor state (written only by the monitor)
    logic [24:0] got_w[$];
    int          lat_err = 0;
    logic        lo_pend = 1'b0;

    // Capture every write and check it follows a low-byte transfer by one cycle
    always @(negedge clk) begin
        if (m_wr_en) got_w.push_back({m_wr_addr, m_wr_data});
        if (m_wr_en !== lo_pend) lat_err <= lat_err + 1;
        lo_pend <= rst && m_ready && s_valid && idx[0];
    end

    // Word-level reference: pair bytes, stop on terminator or full memory
    task automatic model(input int depth);
        logic [7:0]  x;
        logic [15:0] w;
        bit          ended;
        exp_w.delete();
        exp_cons = 0;
        exp_ovf  = 1'b0;
        exp_chk  = 1'b0;
        x        = 8'h00;
        ended    = 1'b0;
        for (int i = 0; i + 1 < stim.size() && !ended; i += 2) begin
            w = {stim[i], stim[i+1]};
            x = x ^ stim[i] ^ stim[i+1];
            exp_cons += 2;
            exp_w.push_back({ADDR_W'(exp_w.size()), w});
            if (w == 16'hFFFF) begin
                ended = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                exp_cons += 1;
                exp_chk = (stim[i+2] != x);
`endif
            end else if (exp_w.size() == depth) begin
                exp_ovf = 1'b1;
                ended   = 1'b1;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ready"}, m_ready, 0);
        check_eq({tag, "_wr_en"}, m_wr_en, 0);
        check_eq({tag, "_addr"}, m_wr_addr, 0);
        check_eq({tag, "_data"}, m_wr_data, 0);
        check_eq({tag, "_wc"}, m_wc, 0);
        check_eq({tag, "_fin"}, m_fin, 0);
        check_eq({tag, "_ovf"}, m_ovf, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check_eq({tag, "_chk"}, m_chk, 0);
`endif
    endtask

    // Drive one load; abort_at >= 0 returns once that many bytes are accepted
    task automatic run_load(input int depth, input bit gaps, input int abort_at);
        int budget;
        int lat0;
        bit will;
        model(depth);
        load_base = got_w.size();
        lat0      = lat_err;
        idx       = 0;
        s_valid   = 1'b0;
        s_bgn     = 1'b1;
        @(posedge clk); #1;
        check_eq("start_fin_clr", m_fin, 0);
        check_eq("start_wc_clr", m_wc, 0);
        check_eq("start_ovf_clr", m_ovf, 0);
        s_bgn  = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
        budget = 0;
        while (!m_fin && budget < 2000) begin
            if (idx == abort_at) return;
            s_data  = (idx < stim.size()) ? stim[idx] : 8'h00;
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (gaps) s_bgn = 1'($urandom_range(0, 1));
            will = m_ready && s_valid;
            @(posedge clk); #1;
            if (will) idx++;
            budget++;
        end
        check_eq("load_timeout", budget < 2000, 1);
        // Keep offering bytes while parked in DONE: none may be taken
        s_bgn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            s_data  = (idx < stim.size()) ? stim[idx] : 8'h00;
            s_valid = 1'b1;
            will    = m_ready && s_valid;
            @(posedge clk); #1;
            if (will) idx++;
        end
        check_eq("done_ready", m_ready, 0);
        s_bgn   = 1'b0;
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("bytes_consumed", idx, exp_cons);
        check_eq("write_count", got_w.size() - load_base, exp_w.size());
        for (int k = 0; k < exp_w.size() && load_base + k < got_w.size(); k++)
            check_eq("write_word", got_w[load_base + k], exp_w[k]);
        check_eq("word_count", m_wc, exp_w.size());
        check_eq("fin_file", m_fin, 1);
        check_eq("overflow", m_ovf, exp_ovf);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check_eq("chk_err", m_chk, exp_chk);
`endif
        check_eq("wr_latency", lat_err - lat0, 0);
    endtask

    task automatic basic_stream();
        stim = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF};
`ifdef INSTR_LOADER_CHECKSUM_EN
        stim.push_back(8'h40);
`endif
        stim.push_back(8'h55);
        stim.push_back(8'h66);
        stim.push_back(8'h77);
        stim.push_back(8'h88);
    endtask

    task automatic random_stream(input int nwords);
        logic [15:0] w;
        logic [7:0]  x;
        stim.delete();
        x = 8'h00;
        for (int k = 0; k < nwords - 1; k++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:8] = 8'hFF;
            if (w == 16'hFFFF) w = 16'hFFFE;
            stim.push_back(w[15:8]);
            stim.push_back(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
        end
        stim.push_back(8'hFF);
        stim.push_back(8'hFF);
`ifdef INSTR_LOADER_CHECKSUM_EN
        stim.push_back($urandom_range(0, 1) ? x : 8'(x + 8'd1));
`endif
        for (int k = 0; k < 4; k++) stim.push_back(8'($urandom));
    endtask

    initial begin
        int b0;
        rst     = 1'b0;
        s_bgn   = 1'b0;
        sel     = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        idx     = 0;
        #12;
        check_zero("reset");
        @(negedge clk) rst = 1'b1;

        // Basic load, in_valid always high
        basic_stream();
        run_load(512, 0, -1);
        check_eq("basic_w0", got_w[load_base],     {9'd0, 16'h1234});
        check_eq("basic_w1", got_w[load_base + 1], {9'd1, 16'hABCD});
        check_eq("basic_w2", got_w[load_base + 2], {9'd2, 16'hFFFF});
        check_eq("basic_wc", m_wc, 3);

        // Restart with gaps and bgn noise during the load
        basic_stream();
        run_load(512, 1, -1);

        // Random programs
        for (int t = 0; t < 10; t++) begin
            random_stream($urandom_range(1, 9));
            run_load(512, t[0], -1);
        end

        // Reset between the high and low bytes of word 2
        basic_stream();
        b0 = got_w.size();
        run_load(512, 0, 3);
        rst = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("midrst_writes", got_w.size() - b0, 1);
        rst = 1'b1;
        basic_stream();
        run_load(512, 0, -1);
        check_eq("reload_w0", got_w[load_base], {9'd0, 16'h1234});

        // Overflow on the DEPTH=4 instance
        sel = 1'b1;
        @(negedge clk);
        stim = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04,
                 8'h05, 8'h05, 8'hFF, 8'hFF, 8'h00, 8'h00};
        run_load(4, 0, -1);
        check_eq("ovf_flag", m_ovf, 1);
        check_eq("ovf_wc", m_wc, 4);
        check_eq("ovf_bytes", idx, 8);
        check_eq("ovf_last", got_w[got_w.size() - 1], {9'd3, 16'h0404});

        // Terminator landing exactly on the last address is not an overflow
        stim = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'hFF, 8'hFF,
                 8'h00, 8'h00, 8'h00, 8'h00};
        run_load(4, 1, -1);
        check_eq("end_at_last_ovf", m_ovf, 0);
        sel = 1'b0;
        @(negedge clk);

`ifdef INSTR_LOADER_CHECKSUM_EN
        stim = '{8'h12, 8'h34, 8'hFF, 8'hFF, 8'h26, 8'h00, 8'h00};
        run_load(512, 0, -1);
        check_eq("chk_good", m_chk, 0);
        stim = '{8'h12, 8'h34, 8'hFF, 8'hFF, 8'h27, 8'h00, 8'h00};
        run_load(512, 0, -1);
        check_eq("chk_bad", m_chk, 1);
        check_eq("chk_bad_fin", m_fin, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
